contrast_apply: RTL and testbench

Per-pixel contrast stretch stage directly downstream of the frame min/max/multiplier calculator. It takes the raw 14-bit ADC pixel stream and the per-frame MIN, MAX and MULT_CONTRAST values. It maps each pixel to an 8-bit display value: ((clamp(DATA_IN) − MIN) × MULT) >> SHIFT, saturated to 255. It also counts saturated pixels per frame for the exposure/contrast controller.

---
 rtl/contrast_apply_if.sv | 29 ++
 rtl/contrast_apply.sv | 132 +++++++++++++
 tb/tb_contrast_apply.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/contrast_apply_if.sv
// Pixel stream and per-frame parameter bundle for contrast_apply.
// Handshake: a pixel is transferred on every rising edge where ENABLE is high; the output
// side presents one DATA_OUT per input pixel with OUT_VALID high, and there is no ready/backpressure.
interface contrast_apply_if #(
   parameter int ADC_W = 14,
   parameter int OUT_W = 8
);
   logic             RESET_FRAME;
   logic             ENABLE;
   logic [ADC_W-1:0] DATA_IN;
   logic [ADC_W-1:0] MIN;
   logic [ADC_W-1:0] MAX;
   logic [7:0]       MULT_CONTRAST;
   logic [OUT_W-1:0] DATA_OUT;
   logic             OUT_VALID;
   logic [19:0]      SAT_COUNT;
   logic             PARAM_BYPASS;
   logic             LOAD_PEND;

   modport master (
      output RESET_FRAME, ENABLE, DATA_IN, MIN, MAX, MULT_CONTRAST,
      input  DATA_OUT, OUT_VALID, SAT_COUNT, PARAM_BYPASS, LOAD_PEND
   );

   modport slave (
      input  RESET_FRAME, ENABLE, DATA_IN, MIN, MAX, MULT_CONTRAST,
      output DATA_OUT, OUT_VALID, SAT_COUNT, PARAM_BYPASS, LOAD_PEND
   );
endinterface

// File: rtl/contrast_apply.sv
// Three-stage per-pixel contrast stretch with two-step per-frame parameter load
// and a saturating per-frame count of clipped pixels.
module contrast_apply #(
   parameter int ADC_W      = 14,
   parameter int OUT_W      = 8,
   parameter int SHIFT      = 4,
   parameter int BYPASS_MSB = 13
) (
   input  logic             CLK100,
   input  logic             RESET,
   contrast_apply_if.slave  bus
);
   localparam int PROD_W = ADC_W + 8;
   localparam int S_W    = PROD_W - SHIFT;
   localparam logic [19:0] SAT_MAX = '1;

   typedef enum logic {LD_IDLE, LD_PEND} ld_state_e;

   ld_state_e        ld_q, ld_d;
   logic [ADC_W-1:0] act_min_q, act_min_d, act_max_q, act_max_d;
   logic [7:0]       act_mult_q, act_mult_d;

   logic [ADC_W-1:0] clamp_c, diff_c;
   logic [ADC_W-1:0] diff1_q;
   logic [7:0]       mult1_q;
   logic [OUT_W-1:0] byp1_q;
   logic             v1_q;

   logic [PROD_W-1:0] prod2_q;
   logic [OUT_W-1:0]  byp2_q;
   logic              mz2_q;
   logic              v2_q;

   logic [S_W-1:0]   s_c;
   logic             sat_c;
   logic [OUT_W-1:0] dout_c;
   logic [19:0]      sat_cnt_q, sat_cnt_d, sat_count_q, sat_count_d, sat_acc_c;
   logic [OUT_W-1:0] dout_q;
   logic             oval_q;
   logic             bypass_q;

   // MULT is taken on the strobe edge; MIN/MAX only become stable one cycle later.
   always_comb begin
      ld_d       = ld_q;
      act_min_d  = act_min_q;
      act_max_d  = act_max_q;
      act_mult_d = act_mult_q;
      if (bus.RESET_FRAME) begin
         act_mult_d = bus.MULT_CONTRAST;
         ld_d       = LD_PEND;
      end else if (ld_q == LD_PEND) begin
         act_min_d = bus.MIN;
         act_max_d = (bus.MAX < bus.MIN) ? bus.MIN : bus.MAX;
         ld_d      = LD_IDLE;
      end
   end

   always_comb begin
      clamp_c = bus.DATA_IN;
      if (bus.DATA_IN < act_min_q)      clamp_c = act_min_q;
      else if (bus.DATA_IN > act_max_q) clamp_c = act_max_q;
      diff_c = clamp_c - act_min_q;
   end

   // Output stage: bypass pixels never count as saturated.
   always_comb begin
      s_c    = prod2_q[PROD_W-1:SHIFT];
      sat_c  = v2_q && !mz2_q && (|s_c[S_W-1:OUT_W]);
      dout_c = s_c[OUT_W-1:0];
      if (mz2_q)      dout_c = byp2_q;
      else if (sat_c) dout_c = '1;
      sat_acc_c = sat_cnt_q;
      if (sat_c && (sat_cnt_q != SAT_MAX)) sat_acc_c = sat_cnt_q + 20'd1;
      sat_cnt_d   = sat_acc_c;
      sat_count_d = sat_count_q;
      if (bus.RESET_FRAME) begin
         sat_count_d = sat_acc_c;
         sat_cnt_d   = {19'd0, sat_c};
      end
   end

   always_ff @(posedge CLK100) begin
      if (RESET) begin
         ld_q        <= LD_IDLE;
         act_min_q   <= '0;
         act_max_q   <= '1;
         act_mult_q  <= '0;
         diff1_q     <= '0;
         mult1_q     <= '0;
         byp1_q      <= '0;
         v1_q        <= 1'b0;
         prod2_q     <= '0;
         byp2_q      <= '0;
         mz2_q       <= 1'b1;
         v2_q        <= 1'b0;
         dout_q      <= '0;
         oval_q      <= 1'b0;
         sat_cnt_q   <= '0;
         sat_count_q <= '0;
         bypass_q    <= 1'b1;
      end else begin
         ld_q        <= ld_d;
         act_min_q   <= act_min_d;
         act_max_q   <= act_max_d;
         act_mult_q  <= act_mult_d;
         v1_q        <= bus.ENABLE;
         v2_q        <= v1_q;
         oval_q      <= v2_q;
         sat_cnt_q   <= sat_cnt_d;
         sat_count_q <= sat_count_d;
         bypass_q    <= (act_mult_d == 8'd0);
         // Each pixel carries its own multiplier so a reload never alters in-flight pixels.
         if (bus.ENABLE) begin
            diff1_q <= diff_c;
            mult1_q <= act_mult_q;
            byp1_q  <= bus.DATA_IN[BYPASS_MSB -: OUT_W];
         end
         if (v1_q) begin
            prod2_q <= PROD_W'(diff1_q) * PROD_W'(mult1_q);
            byp2_q  <= byp1_q;
            mz2_q   <= (mult1_q == 8'd0);
         end
         if (v2_q) dout_q <= dout_c;
      end
   end

   assign bus.DATA_OUT     = dout_q;
   assign bus.OUT_VALID    = oval_q;
   assign bus.SAT_COUNT    = sat_count_q;
   assign bus.PARAM_BYPASS = bypass_q;
   assign bus.LOAD_PEND    = (ld_q == LD_PEND);
endmodule

// File: tb/tb_contrast_apply.sv
// Directed bench for contrast_apply: hand-computed pixel results, latency,
// parameter-load ordering, saturation counting and reset behaviour.
module tb_contrast_apply;
   logic CLK100;
   logic RESET;
   int   errors;
   int   checks;
   int   cyc;
   logic [7:0] out_q[$];
   int         ocyc_q[$];
   int         icyc_q[$];

   contrast_apply_if bus ();

   contrast_apply dut (
      .CLK100 (CLK100),
      .RESET  (RESET),
      .bus    (bus)
   );

   initial CLK100 = 1'b0;
   always #5 CLK100 = ~CLK100;

   always @(posedge CLK100) cyc <= cyc + 1;

   always @(negedge CLK100) begin
      if (bus.OUT_VALID === 1'b1) begin
         out_q.push_back(bus.DATA_OUT);
         ocyc_q.push_back(cyc);
      end
   end

   task automatic drive(input logic rf, input logic en, input logic [13:0] d);
      bus.RESET_FRAME = rf;
      bus.ENABLE      = en;
      bus.DATA_IN     = d;
      if (en) icyc_q.push_back(cyc);
      @(negedge CLK100);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 14'd0);
   endtask

   task automatic set_params(input logic [13:0] mn, input logic [13:0] mx, input logic [7:0] mult);
      bus.MIN           = mn;
      bus.MAX           = mx;
      bus.MULT_CONTRAST = mult;
   endtask

   task automatic flush();
      out_q.delete();
      ocyc_q.delete();
      icyc_q.delete();
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      idle(2);
      RESET = 1'b0;
      idle(1);
      checks++;
      if (bus.DATA_OUT !== 8'd0) begin errors++; $display("FAIL reset_data_out: got %0d expected 0", bus.DATA_OUT); end
      checks++;
      if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.OUT_VALID); end
      checks++;
      if (bus.SAT_COUNT !== 20'd0) begin errors++; $display("FAIL reset_sat_count: got %0d expected 0", bus.SAT_COUNT); end
      checks++;
      if (bus.PARAM_BYPASS !== 1'b1) begin errors++; $display("FAIL reset_param_bypass: got %b expected 1", bus.PARAM_BYPASS); end
      checks++;
      if (bus.LOAD_PEND !== 1'b0) begin errors++; $display("FAIL reset_load_pend: got %b expected 0", bus.LOAD_PEND); end
   endtask

   task automatic test_bypass();
      logic [7:0] exp_v[2];
      exp_v[0] = 8'hFF;
      exp_v[1] = 8'h48;
      flush();
      drive(1'b0, 1'b1, 14'h3FC0);
      drive(1'b0, 1'b1, 14'h1234);
      idle(4);
      checks++;
      if (out_q.size() !== 2) begin
         errors++; $display("FAIL bypass_count: got %0d expected 2", out_q.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_q[i] !== exp_v[i]) begin errors++; $display("FAIL bypass_data[%0d]: got %0h expected %0h", i, out_q[i], exp_v[i]); end
         end
      end
      checks++;
      if (bus.PARAM_BYPASS !== 1'b1) begin errors++; $display("FAIL bypass_flag: got %b expected 1", bus.PARAM_BYPASS); end
      set_params(14'd0, 14'h3FFF, 8'd0);
      drive(1'b1, 1'b0, 14'd0);
      checks++;
      if (bus.SAT_COUNT !== 20'd0) begin errors++; $display("FAIL bypass_sat_count: got %0d expected 0", bus.SAT_COUNT); end
      idle(1);
   endtask

   task automatic test_normal();
      logic [7:0] exp_v[3];
      exp_v[0] = 8'd0;
      exp_v[1] = 8'd100;
      exp_v[2] = 8'd40;
      set_params(14'd1000, 14'd5000, 8'd4);
      drive(1'b1, 1'b0, 14'd0);
      checks++;
      if (bus.LOAD_PEND !== 1'b1) begin errors++; $display("FAIL normal_load_pend_set: got %b expected 1", bus.LOAD_PEND); end
      checks++;
      if (bus.PARAM_BYPASS !== 1'b0) begin errors++; $display("FAIL normal_param_bypass: got %b expected 0", bus.PARAM_BYPASS); end
      drive(1'b0, 1'b0, 14'd0);
      checks++;
      if (bus.LOAD_PEND !== 1'b0) begin errors++; $display("FAIL normal_load_pend_clr: got %b expected 0", bus.LOAD_PEND); end
      flush();
      drive(1'b0, 1'b1, 14'd1000);
      drive(1'b0, 1'b1, 14'd1400);
      drive(1'b0, 1'b1, 14'd1160);
      idle(4);
      checks++;
      if (out_q.size() !== 3) begin
         errors++; $display("FAIL normal_count: got %0d expected 3", out_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_q[i] !== exp_v[i]) begin errors++; $display("FAIL normal_data[%0d]: got %0d expected %0d", i, out_q[i], exp_v[i]); end
            checks++;
            if (ocyc_q[i] - icyc_q[i] !== 3) begin errors++; $display("FAIL normal_latency[%0d]: got %0d expected 3", i, ocyc_q[i] - icyc_q[i]); end
         end
      end
   endtask

   task automatic test_clamp_saturate();
      logic [7:0] exp_v[3];
      exp_v[0] = 8'd0;
      exp_v[1] = 8'd255;
      exp_v[2] = 8'd255;
      flush();
      drive(1'b0, 1'b1, 14'd500);
      drive(1'b0, 1'b1, 14'd5000);
      drive(1'b0, 1'b1, 14'd6000);
      idle(4);
      checks++;
      if (out_q.size() !== 3) begin
         errors++; $display("FAIL clamp_count: got %0d expected 3", out_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_q[i] !== exp_v[i]) begin errors++; $display("FAIL clamp_data[%0d]: got %0d expected %0d", i, out_q[i], exp_v[i]); end
         end
      end
      drive(1'b1, 1'b0, 14'd0);
      checks++;
      if (bus.SAT_COUNT !== 20'd2) begin errors++; $display("FAIL clamp_sat_count: got %0d expected 2", bus.SAT_COUNT); end
      idle(1);
   endtask

   task automatic test_mid_pipe();
      flush();
      drive(1'b0, 1'b1, 14'd1400);
      set_params(14'd2000, 14'd5000, 8'd8);
      drive(1'b1, 1'b0, 14'd0);
      drive(1'b0, 1'b1, 14'd1400);
      idle(4);
      checks++;
      if (out_q.size() !== 2) begin
         errors++; $display("FAIL midpipe_count: got %0d expected 2", out_q.size());
      end else begin
         checks++;
         if (out_q[0] !== 8'd100) begin errors++; $display("FAIL midpipe_first: got %0d expected 100", out_q[0]); end
         checks++;
         if (out_q[1] !== 8'd200) begin errors++; $display("FAIL midpipe_second: got %0d expected 200", out_q[1]); end
      end
   endtask

   task automatic test_strobe_with_pixel();
      flush();
      set_params(14'd2000, 14'd5000, 8'd2);
      drive(1'b1, 1'b1, 14'd2400);
      drive(1'b0, 1'b1, 14'd2400);
      idle(4);
      checks++;
      if (out_q.size() !== 2) begin
         errors++; $display("FAIL strobepix_count: got %0d expected 2", out_q.size());
      end else begin
         checks++;
         if (out_q[0] !== 8'd200) begin errors++; $display("FAIL strobepix_old_mult: got %0d expected 200", out_q[0]); end
         checks++;
         if (out_q[1] !== 8'd50) begin errors++; $display("FAIL strobepix_new_mult: got %0d expected 50", out_q[1]); end
      end
   endtask

   task automatic test_back_to_back();
      flush();
      set_params(14'd1000, 14'd5000, 8'd4);
      drive(1'b1, 1'b0, 14'd0);
      set_params(14'd1500, 14'd5000, 8'd8);
      drive(1'b1, 1'b0, 14'd0);
      checks++;
      if (bus.LOAD_PEND !== 1'b1) begin errors++; $display("FAIL b2b_load_pend: got %b expected 1", bus.LOAD_PEND); end
      drive(1'b0, 1'b0, 14'd0);
      drive(1'b0, 1'b1, 14'd1900);
      idle(4);
      checks++;
      if (out_q.size() !== 1) begin
         errors++; $display("FAIL b2b_count: got %0d expected 1", out_q.size());
      end else begin
         checks++;
         if (out_q[0] !== 8'd200) begin errors++; $display("FAIL b2b_data: got %0d expected 200", out_q[0]); end
      end
   endtask

   task automatic test_max_lt_min();
      flush();
      set_params(14'd3000, 14'd2000, 8'd4);
      drive(1'b1, 1'b0, 14'd0);
      drive(1'b0, 1'b0, 14'd0);
      drive(1'b0, 1'b1, 14'd4000);
      drive(1'b0, 1'b1, 14'd1000);
      drive(1'b0, 1'b1, 14'd2999);
      idle(4);
      checks++;
      if (out_q.size() !== 3) begin
         errors++; $display("FAIL maxltmin_count: got %0d expected 3", out_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_q[i] !== 8'd0) begin errors++; $display("FAIL maxltmin_data[%0d]: got %0d expected 0", i, out_q[i]); end
         end
      end
   endtask

   task automatic test_sat_same_cycle();
      set_params(14'd1000, 14'd5000, 8'd4);
      drive(1'b1, 1'b0, 14'd0);
      checks++;
      if (bus.SAT_COUNT !== 20'd0) begin errors++; $display("FAIL samecyc_prev_frame: got %0d expected 0", bus.SAT_COUNT); end
      drive(1'b0, 1'b0, 14'd0);
      flush();
      drive(1'b0, 1'b1, 14'd6000);
      drive(1'b0, 1'b0, 14'd0);
      drive(1'b1, 1'b0, 14'd0);
      checks++;
      if (bus.SAT_COUNT !== 20'd1) begin errors++; $display("FAIL samecyc_included: got %0d expected 1", bus.SAT_COUNT); end
      drive(1'b0, 1'b0, 14'd0);
      drive(1'b1, 1'b0, 14'd0);
      checks++;
      if (bus.SAT_COUNT !== 20'd1) begin errors++; $display("FAIL samecyc_restart_one: got %0d expected 1", bus.SAT_COUNT); end
      checks++;
      if (out_q.size() !== 1 || out_q[0] !== 8'd255) begin errors++; $display("FAIL samecyc_data: got %0d outputs expected one 255", out_q.size()); end
      idle(1);
   endtask

   task automatic test_reset_midframe();
      flush();
      drive(1'b0, 1'b1, 14'd1400);
      drive(1'b0, 1'b0, 14'd0);
      drive(1'b0, 1'b1, 14'd1400);
      RESET = 1'b1;
      drive(1'b0, 1'b0, 14'd0);
      RESET = 1'b0;
      idle(4);
      checks++;
      if (out_q.size() !== 1) begin
         errors++; $display("FAIL rstmid_count: got %0d expected 1", out_q.size());
      end else begin
         checks++;
         if (out_q[0] !== 8'd100) begin errors++; $display("FAIL rstmid_data: got %0d expected 100", out_q[0]); end
      end
      checks++;
      if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", bus.OUT_VALID); end
      checks++;
      if (bus.DATA_OUT !== 8'd0) begin errors++; $display("FAIL rstmid_data_out: got %0d expected 0", bus.DATA_OUT); end
      checks++;
      if (bus.SAT_COUNT !== 20'd0) begin errors++; $display("FAIL rstmid_sat_count: got %0d expected 0", bus.SAT_COUNT); end
      checks++;
      if (bus.PARAM_BYPASS !== 1'b1) begin errors++; $display("FAIL rstmid_param_bypass: got %b expected 1", bus.PARAM_BYPASS); end
   endtask

   task automatic test_counter_sat();
      set_params(14'd1000, 14'd5000, 8'd4);
      drive(1'b1, 1'b0, 14'd0);
      drive(1'b0, 1'b0, 14'd0);
      // Preload the counter close to full instead of streaming a million pixels.
      force dut.sat_cnt_q = 20'hFFFFD;
      #1;
      release dut.sat_cnt_q;
      @(negedge CLK100);
      flush();
      repeat (5) drive(1'b0, 1'b1, 14'd6000);
      idle(4);
      drive(1'b1, 1'b0, 14'd0);
      checks++;
      if (bus.SAT_COUNT !== 20'hFFFFF) begin errors++; $display("FAIL ctrsat_sat_count: got %0h expected fffff", bus.SAT_COUNT); end
      checks++;
      if (out_q.size() !== 5) begin errors++; $display("FAIL ctrsat_count: got %0d expected 5", out_q.size()); end
      idle(1);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      cyc    = 0;
      RESET  = 1'b1;
      bus.RESET_FRAME   = 1'b0;
      bus.ENABLE        = 1'b0;
      bus.DATA_IN       = '0;
      bus.MIN           = '0;
      bus.MAX           = '0;
      bus.MULT_CONTRAST = '0;
      @(negedge CLK100);
      test_reset();
      test_bypass();
      test_normal();
      test_clamp_saturate();
      test_mid_pipe();
      test_strobe_with_pixel();
      test_back_to_back();
      test_max_lt_min();
      test_sat_same_cycle();
      test_reset_midframe();
      test_counter_sat();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
